// File: rtl/riscv_pkg.sv
// Shared RV32I datapath definitions: word width, reset vector, bubble encoding
// and the fetch-stage state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store with a combinational read port and a
// synchronous write port used for loading a program image.
module instruction_memory
  import riscv_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic            clk,
  input  logic            we,
  input  logic [XLEN-1:0] waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] addr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [2**DEPTH_LOG2];

  // Byte offset and high address bits are ignored; the store aliases.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[XLEN-1:DEPTH_LOG2+2], addr[1:0],
                              waddr[XLEN-1:DEPTH_LOG2+2], waddr[1:0]};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr[DEPTH_LOG2+1:2]] <= wdata;
    end
  end

  assign rdata = mem[addr[DEPTH_LOG2+1:2]];

endmodule

// File: rtl/pc_register.sv
// Program counter flop with its next-PC select: redirect load, sequential
// advance, or hold.
module pc_register
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  input  logic            load,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_next;

  // A redirect load wins over sequential advance; the add wraps mod 2^32.
  always_comb begin
    pc_next = pc;
    if (load) begin
      pc_next = load_pc;
    end else if (advance) begin
      pc_next = pc + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: BOOT/RUN/FAULT control, PC register instance and
// the IF/ID pipeline register feeding the decoder.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            flush,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [XLEN-1:0] if_id_instr,
  output logic            misaligned_fault
);

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic            redirect_aligned;
  logic            pc_advance;
  logic            pc_load;
  logic            capture;
  logic            invalidate;
  logic [XLEN-1:0] pc;

  assign redirect_aligned = is_word_aligned(redirect_pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     if (redirect_valid && !redirect_aligned) state_next = FAULT;
      FAULT:   if (redirect_valid && redirect_aligned) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  // In RUN the priority is redirect, then flush, then stall, then fetch.
  always_comb begin
    pc_advance = 1'b0;
    pc_load    = 1'b0;
    capture    = 1'b0;
    invalidate = 1'b0;
    case (state)
      BOOT: begin
        invalidate = 1'b1;
      end
      RUN: begin
        if (redirect_valid) begin
          invalidate = 1'b1;
          pc_load    = redirect_aligned;
        end else if (flush) begin
          invalidate = 1'b1;
          pc_advance = !stall;
        end else if (!stall) begin
          capture    = 1'b1;
          pc_advance = 1'b1;
        end
      end
      FAULT: begin
        invalidate = 1'b1;
        pc_load    = redirect_valid && redirect_aligned;
      end
      default: begin
        invalidate = 1'b1;
      end
    endcase
  end

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (pc_advance),
    .load    (pc_load),
    .load_pc (redirect_pc),
    .pc      (pc)
  );

  assign imem_addr = pc;

  // Invalidation leaves the captured PC fields alone so only valid/instr move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_valid    <= 1'b0;
      if_id_pc       <= '0;
      if_id_pc_plus4 <= '0;
      if_id_instr    <= NOP_INSTR;
    end else if (invalidate) begin
      if_id_valid    <= 1'b0;
      if_id_instr    <= NOP_INSTR;
    end else if (capture) begin
      if_id_valid    <= 1'b1;
      if_id_pc       <= pc;
      if_id_pc_plus4 <= pc + PC_STEP;
      if_id_instr    <= imem_instr;
    end
  end

  assign misaligned_fault = (state == FAULT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage fed by a real instruction_memory.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
  logic        misaligned_fault;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;

  int passCount;
  int checkCount;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        flush;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        fault;
  } vec_t;

  vec_t vecs [20];

  fetch_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush            (flush),
    .imem_addr        (imem_addr),
    .imem_instr       (imem_instr),
    .if_id_valid      (if_id_valid),
    .if_id_pc         (if_id_pc),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .if_id_instr      (if_id_instr),
    .misaligned_fault (misaligned_fault)
  );

  instruction_memory u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .addr  (imem_addr),
    .rdata (imem_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: each word encodes its own low address bits.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {16'hC0DE, 6'b0, a[9:0]};
  endfunction

  function automatic vec_t mk(input logic s, input logic rv, input logic [31:0] rpc,
                              input logic f, input logic [31:0] addr, input logic valid,
                              input logic [31:0] pc, input logic [31:0] pc4,
                              input logic [31:0] instr, input logic fault);
    vec_t v;
    v.stall = s; v.rv = rv; v.rpc = rpc; v.flush = f;
    v.addr = addr; v.valid = valid; v.pc = pc; v.pc4 = pc4;
    v.instr = instr; v.fault = fault;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [31:0] addr, input logic valid,
                          input logic [31:0] pc, input logic [31:0] pc4,
                          input logic [31:0] instr, input logic fault);
    checkOutput({tag, ".imem_addr"}, imem_addr, addr);
    checkOutput({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, valid});
    checkOutput({tag, ".pc"}, if_id_pc, pc);
    checkOutput({tag, ".pc_plus4"}, if_id_pc_plus4, pc4);
    checkOutput({tag, ".instr"}, if_id_instr, instr);
    checkOutput({tag, ".fault"}, {31'b0, misaligned_fault}, {31'b0, fault});
  endtask

  task automatic applyStimulus(input logic s, input logic rv, input logic [31:0] rpc,
                               input logic f);
    stall = s;
    redirect_valid = rv;
    redirect_pc = rpc;
    flush = f;
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    rst_n = 1'b0;
    mem_we = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

    // Program load while the fetch stage is held in reset.
    #2;
    mem_we = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem_waddr = i << 2;
      mem_wdata = word_at(i << 2);
      step();
    end
    mem_we = 1'b0;

    vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0000_0000, 0, 32'h0,        32'h0,        NOP,                      0);
    vecs[1]  = mk(0, 0, 32'h0,        0, 32'h0000_0004, 1, 32'h0,        32'h4,        word_at(32'h0),           0);
    vecs[2]  = mk(0, 0, 32'h0,        0, 32'h0000_0008, 1, 32'h4,        32'h8,        word_at(32'h4),           0);
    vecs[3]  = mk(1, 0, 32'h0,        0, 32'h0000_0008, 1, 32'h4,        32'h8,        word_at(32'h4),           0);
    vecs[4]  = mk(1, 0, 32'h0,        0, 32'h0000_0008, 1, 32'h4,        32'h8,        word_at(32'h4),           0);
    vecs[5]  = mk(1, 0, 32'h0,        0, 32'h0000_0008, 1, 32'h4,        32'h8,        word_at(32'h4),           0);
    vecs[6]  = mk(0, 0, 32'h0,        0, 32'h0000_000C, 1, 32'h8,        32'hC,        word_at(32'h8),           0);
    vecs[7]  = mk(0, 0, 32'h0,        0, 32'h0000_0010, 1, 32'hC,        32'h10,       word_at(32'hC),           0);
    vecs[8]  = mk(1, 1, 32'h40,       0, 32'h0000_0040, 0, 32'hC,        32'h10,       NOP,                      0);
    vecs[9]  = mk(0, 0, 32'h0,        0, 32'h0000_0044, 1, 32'h40,       32'h44,       word_at(32'h40),          0);
    vecs[10] = mk(0, 1, 32'h42,       0, 32'h0000_0044, 0, 32'h40,       32'h44,       NOP,                      1);
    vecs[11] = mk(1, 0, 32'h0,        1, 32'h0000_0044, 0, 32'h40,       32'h44,       NOP,                      1);
    vecs[12] = mk(0, 1, 32'h46,       0, 32'h0000_0044, 0, 32'h40,       32'h44,       NOP,                      1);
    vecs[13] = mk(0, 1, 32'h80,       0, 32'h0000_0080, 0, 32'h40,       32'h44,       NOP,                      0);
    vecs[14] = mk(0, 0, 32'h0,        0, 32'h0000_0084, 1, 32'h80,       32'h84,       word_at(32'h80),          0);
    vecs[15] = mk(0, 0, 32'h0,        1, 32'h0000_0088, 0, 32'h80,       32'h84,       NOP,                      0);
    vecs[16] = mk(1, 0, 32'h0,        1, 32'h0000_0088, 0, 32'h80,       32'h84,       NOP,                      0);
    vecs[17] = mk(0, 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 32'h80,      32'h84,       NOP,                      0);
    vecs[18] = mk(0, 0, 32'h0,        0, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h0,       word_at(32'hFFFF_FFFC),   0);
    vecs[19] = mk(0, 0, 32'h0,        0, 32'h0000_0004, 1, 32'h0,        32'h4,        word_at(32'h0),           0);

    checkAll("reset_held", 32'h0, 1'b0, 32'h0, 32'h0, NOP, 1'b0);

    // Release between edges, then walk the vector table one edge per entry.
    rst_n = 1'b1;
    checkAll("reset_release", 32'h0, 1'b0, 32'h0, 32'h0, NOP, 1'b0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].flush);
      step();
      checkAll($sformatf("vec%0d", i), vecs[i].addr, vecs[i].valid, vecs[i].pc,
               vecs[i].pc4, vecs[i].instr, vecs[i].fault);
    end

    // Asynchronous reset mid-stream, away from any clock edge.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    checkAll("pre_reset", 32'h8, 1'b1, 32'h4, 32'h8, word_at(32'h4), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("async_reset", 32'h0, 1'b0, 32'h0, 32'h0, NOP, 1'b0);
    step();
    checkAll("reset_edge", 32'h0, 1'b0, 32'h0, 32'h0, NOP, 1'b0);
    rst_n = 1'b1;
    step();
    checkAll("boot_bubble", 32'h0, 1'b0, 32'h0, 32'h0, NOP, 1'b0);
    step();
    checkAll("first_fetch", 32'h4, 1'b1, 32'h0, 32'h4, word_at(32'h0), 1'b0);

    // A misaligned redirect issued during BOOT must not fault.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h2, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    checkAll("boot_ignores_redirect", 32'h0, 1'b0, 32'h0, 32'h0, NOP, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32I datapath: holds the program counter, drives the address port of the combinational `instruction_memory`, and captures the returned word into the IF/ID pipeline register for the decoder. Supports stall from hazard logic, PC redirect from branch/jump resolution, flush of the IF/ID register, and a misaligned-target fault state.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INSTR`, 32'h0000_0013, bubble word (`addi x0,x0,0`) placed in IF/ID when invalid.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `stall`  in  1  hold PC and IF/ID contents.
- `redirect_valid`  in  1  load `redirect_pc` as next PC.
- `redirect_pc`  in  32  branch/jump target.
- `flush`  in  1  invalidate IF/ID entry.
- `imem_addr`  out  32  address to `instruction_memory` (equals PC).
- `imem_instr`  in  32  combinational instruction word for `imem_addr`.
- `if_id_valid`  out  1  IF/ID entry holds a real instruction.
- `if_id_pc`  out  32  PC of captured instruction.
- `if_id_pc_plus4`  out  32  `if_id_pc + 4`, for JAL/JALR link.
- `if_id_instr`  out  32  captured instruction, `NOP_INSTR` when invalid.
- `misaligned_fault`  out  1  high while in FAULT state.

## Operation
- States: BOOT, RUN, FAULT.
- BOOT: entered on reset; PC = `RESET_PC`; IF/ID invalid. Unconditionally → RUN next edge (one bubble cycle after reset release).
- RUN, per edge, priority order:
  1. `redirect_valid` with `redirect_pc[1:0] != 0` → FAULT; PC unchanged; IF/ID invalidated.
  2. `redirect_valid` aligned → PC = `redirect_pc`; IF/ID invalidated (wrong-path kill); overrides `stall`.
  3. `flush` (no redirect) → IF/ID invalidated; PC follows stall rule.
  4. `stall` → PC and IF/ID hold.
  5. otherwise → IF/ID ← {valid=1, PC, PC+4, `imem_instr`}; PC = PC + 4.
- FAULT: PC holds; IF/ID invalid; `stall`/`flush` ignored. Aligned `redirect_valid` → PC = `redirect_pc`, → RUN. Misaligned redirect → stay.
- PC arithmetic mod 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000; no fault on wrap.
- Invalidating IF/ID: valid=0, instr=`NOP_INSTR`; `if_id_pc`/`if_id_pc_plus4` hold their old values.
- `imem_addr` is combinational from the PC register; `imem_instr` is sampled same cycle.

## Timing
- Reset values: PC=`RESET_PC`, state=BOOT, `imem_addr`=`RESET_PC`, `if_id_valid`=0, `if_id_instr`=`NOP_INSTR`, `if_id_pc`=0, `if_id_pc_plus4`=0, `misaligned_fault`=0.
- `rst_n` low mid-operation: all of the above immediately, independent of `clk`.
- First valid IF/ID entry (PC=`RESET_PC`) appears 2 edges after reset release (BOOT edge, then capture edge).
- Fetch latency: 1 cycle, address to IF/ID. Throughput: 1 instr/cycle when not stalled.
- Redirect penalty: target instruction valid in IF/ID 2 edges after redirect edge; 1 bubble.
- `misaligned_fault` is a registered state decode; asserts the edge after a misaligned redirect, deasserts the edge after the recovering redirect.

## Structure
- Shared `riscv_pkg`: `NOP_INSTR`, default `RESET_PC`, `XLEN`=32, fetch state enum (BOOT/RUN/FAULT).
- One sub-module: `pc_register` (PC flop + next-PC mux: +4 / redirect / hold, with async reset to `RESET_PC`); FSM and IF/ID register live in `fetch_stage`.
- Bench drives `imem_instr` from a real `instruction_memory` instance.

## Test plan
- Reset, release, run 4 cycles with memory words A,B,C,D at 0,4,8,C → IF/ID valid from edge 2: (0,A),(4,B),(8,C); `if_id_pc_plus4`=4,8,C.
- `stall` high 3 cycles at PC=8 → `imem_addr` stays 8, IF/ID holds (4,B); resumes with (8,C).
- `redirect_valid` + `redirect_pc`=32'h40 while `stall`=1 → next edge PC=40, IF/ID invalid/`NOP_INSTR`; following edge IF/ID=(40,mem[40]).
- `redirect_pc`=32'h42 → `misaligned_fault`=1, PC frozen, valid=0; then `redirect_pc`=32'h80 → fault clears, (80,mem[80]) captured next edge.
- Redirect to 32'hFFFF_FFFC, run 2 cycles → PC wraps to 0, no fault; IF/ID pc_plus4 = 0 for the FFFF_FFFC entry.
- Assert `rst_n` low between clock edges mid-stream → all outputs at reset values immediately; BOOT bubble repeats on release.
